// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage; owns the PC, drives a one-outstanding
//               req/ack memory port and queues {pc,inst} pairs for decode.
// Revision    : 1.0
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ack_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [31:0]      buf_pc_q   [BUF_DEPTH];
    logic [31:0]      buf_inst_q [BUF_DEPTH];
    logic             push, pop, room;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    assign id_valid_o  = (count_q != '0);
    assign id_pc_o     = id_valid_o ? buf_pc_q[head_q]   : 32'h0;
    assign id_inst_o   = id_valid_o ? buf_inst_q[head_q] : 32'h0;
    assign inst_req_o  = req_q;
    assign inst_addr_o = addr_q;

    always_comb begin
        push    = (state_q == S_WAIT) && inst_ack_i && !flush_i;
        pop     = id_valid_o && !stall_i && !flush_i;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        // A request is only launched when the post-edge queue has a free slot.
        room = (count_d < DEPTH_C);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        if (flush_i) begin
            pc_d = new_pc_i;
            case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    addr_d  = new_pc_i;
                end
                S_WAIT, S_DROP: begin
                    if (inst_ack_i) begin
                        state_d = S_WAIT;
                        addr_d  = new_pc_i;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (room) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                S_WAIT: begin
                    if (inst_ack_i) begin
                        pc_d = addr_q + 32'd4;
                        if (room) begin
                            addr_d = addr_q + 32'd4;
                        end else begin
                            state_d = S_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (inst_ack_i) begin
                        state_d = S_WAIT;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload storage needs no reset: outputs are masked by count when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[tail_q]   <= addr_q;
            buf_inst_q[tail_q] <= inst_rdata_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// Testbench for if_fetch: directed scenarios plus randomized stall/flush/latency
// traffic, checked by a decoupled scoreboard against an ideal PC-stream model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] id_pc, id_inst;
    logic        id_valid;

    logic        rst2 = 1'b1;
    logic        req2;
    logic [31:0] addr2, rdata2, id_pc2, id_inst2;
    logic        id_valid2;
    logic        ack2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          fix_lat = 0;
    bit          mem_en = 1'b1;
    bit          junk_en = 1'b0;
    bit          mon_en = 1'b0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign ack2   = req2;
    assign rdata2 = memfn(addr2);

    if_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .new_pc_i(new_pc),
        .inst_req_o(req), .inst_addr_o(addr), .inst_ack_i(ack), .inst_rdata_i(rdata),
        .id_pc_o(id_pc), .id_inst_o(id_inst), .id_valid_o(id_valid)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst2), .stall_i(1'b0), .flush_i(1'b0), .new_pc_i(32'h0),
        .inst_req_o(req2), .inst_addr_o(addr2), .inst_ack_i(ack2), .inst_rdata_i(rdata2),
        .id_pc_o(id_pc2), .id_inst_o(id_inst2), .id_valid_o(id_valid2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ideal decode-side stream: consecutive words starting at the fetch target.
    task automatic restart(input logic [31:0] pc);
        logic [31:0] a;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            a = pc + 32'(4 * i);
            exp_q.push_back({a, memfn(a)});
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc, input int lat);
        mon_en  = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        new_pc  = 32'h0;
        fix_lat = lat;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        restart(start_pc);
        mon_en = 1'b1;
    endtask

    // Memory model: fixed or random latency, optional spurious acks while idle.
    initial begin : memory
        int lat;
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_en) begin
                ack = 1'b0;
                lat = (fix_lat < 0) ? 0 : fix_lat;
            end else if (req) begin
                if (lat == 0) begin
                    ack   = 1'b1;
                    rdata = memfn(addr);
                    lat   = (fix_lat < 0) ? int'($urandom_range(0, 3)) : fix_lat;
                end else begin
                    ack = 1'b0;
                    lat--;
                end
            end else begin
                ack   = junk_en && ($urandom_range(0, 4) == 0);
                rdata = $urandom;
            end
        end
    end

    initial begin : monitor
        logic        p_flush, p_req, p_ack;
        logic [31:0] p_addr;
        logic [63:0] e;
        p_flush = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                p_flush = 1'b0;
                p_req   = 1'b0;
                p_ack   = 1'b0;
            end else begin
                if (!id_valid) begin
                    chk("empty_pc", id_pc, 32'h0);
                    chk("empty_inst", id_inst, 32'h0);
                end
                if (p_flush) chk("flush_clears_valid", 32'(id_valid), 32'd0);
                if (p_req && !p_ack) begin
                    chk("req_hold", 32'(req), 32'd1);
                    chk("addr_hold", addr, p_addr);
                end
                if (id_valid && !stall && !flush) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_underflow: got pc %h expected none", id_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("id_pc", id_pc, e[63:32]);
                        chk("id_inst", id_inst, e[31:0]);
                    end
                end
                p_flush = flush;
                p_req   = req;
                p_ack   = ack;
                p_addr  = addr;
            end
        end
    end

    initial begin : stimulus
        int vc;
        bit found;

        // Reset state, first request, then zero-wait streaming without gaps.
        fix_lat = 0;
        @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_addr", addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        restart(32'h0);
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        chk("first_req", 32'(req), 32'd1);
        chk("first_addr", addr, 32'h0);
        @(posedge clk);
        vc = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (id_valid) vc++;
        end
        chk("zero_wait_no_gaps", 32'(vc), 32'd18);

        // Stall fills the queue and idles the memory port.
        do_reset(32'h0, 0);
        stall = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_req_idle", 32'(req), 32'd0);
        chk("stall_head_pc", id_pc, 32'h0);
        chk("stall_valid", 32'(id_valid), 32'd1);
        @(posedge clk);
        #1;
        stall = 1'b0;
        repeat (6) @(posedge clk);

        // Flush during a 3-cycle-latency fetch: stale word discarded.
        do_reset(32'h0, 3);
        @(posedge clk);
        #1;
        flush  = 1'b1;
        new_pc = 32'h100;
        restart(32'h100);
        @(posedge clk);
        #1;
        flush = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (id_valid) found = 1'b1;
        end
        chk("redirect_valid_seen", 32'(found), 32'd1);
        if (found) chk("redirect_first_pc", id_pc, 32'h100);
        repeat (8) @(posedge clk);

        // Flush, ack and stall in the same cycle.
        do_reset(32'h0, 0);
        repeat (6) @(posedge clk);
        #1;
        stall  = 1'b1;
        flush  = 1'b1;
        new_pc = 32'h200;
        restart(32'h200);
        @(posedge clk);
        #1;
        stall = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("fas_valid", 32'(id_valid), 32'd0);
        chk("fas_addr", addr, 32'h200);
        chk("fas_req", 32'(req), 32'd1);
        repeat (6) @(posedge clk);

        // Asynchronous reset while a request is outstanding.
        do_reset(32'h0, 3);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("async_rst_req", 32'(req), 32'd0);
        chk("async_rst_valid", 32'(id_valid), 32'd0);
        chk("async_rst_addr", addr, 32'h0);

        // PC wrap-around on the second instance.
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        @(posedge clk);
        #2;
        chk("wrap_req", 32'(req2), 32'd1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        @(posedge clk);
        #2;
        chk("wrap_addr1", addr2, 32'h0);
        @(negedge clk);
        chk("wrap_id_pc0", id_pc2, 32'hFFFF_FFFC);
        chk("wrap_id_inst0", id_inst2, memfn(32'hFFFF_FFFC));
        @(negedge clk);
        chk("wrap_id_pc1", id_pc2, 32'h0);
        chk("wrap_id_inst1", id_inst2, memfn(32'h0));

        // Randomized traffic.
        junk_en = 1'b1;
        do_reset(32'h0, -1);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 19) == 0);
            if (flush) begin
                new_pc = $urandom;
                restart(new_pc);
            end
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        flush = 1'b0;
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
